// File: rtl/io_mmio_ctrl_pkg.sv
// Shared definitions for the memory-mapped I/O block: register offsets,
// status-word bit positions and small decode helpers.
package io_mmio_ctrl_pkg;

    // Word offsets decoded from Addr[7:0]
    localparam logic [7:0] IO_UART_CTRL = 8'h00;
    localparam logic [7:0] IO_UART_RX   = 8'h04;
    localparam logic [7:0] IO_UART_TX   = 8'h08;
    localparam logic [7:0] IO_CYCLE     = 8'h10;
    localparam logic [7:0] IO_INSTRET   = 8'h14;
    localparam logic [7:0] IO_CTR_RST   = 8'h18;

    // Bit positions inside the UART status word
    localparam int CTRL_TX_READY = 0;
    localparam int CTRL_RX_FULL  = 1;
    localparam int CTRL_TX_OVF   = 2;

    // Registers are word-aligned; byte stores hit the register of their word
    function automatic logic [7:0] word_offset(input logic [7:0] addr);
        return {addr[7:2], 2'b00};
    endfunction

    // Store data arrives lane-shifted, so the TX byte sits in the addressed lane
    function automatic logic [7:0] lane_byte(input logic [31:0] data,
                                             input logic [1:0]  lane);
        return data[8*lane +: 8];
    endfunction

endpackage

// File: rtl/io_mmio_ctrl_tx_fifo.sv
// Circular TX byte FIFO. DEPTH must be a power of two so the pointers wrap
// by plain overflow. A push while full is accepted only if a pop happens in
// the same cycle; the caller detects and reports dropped bytes.
module io_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_push,
    input  logic [7:0] i_din,
    input  logic       i_pop,
    output logic       o_full,
    output logic       o_empty,
    output logic [7:0] o_dout
);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage, pointers and occupancy; simultaneous push/pop leaves the count unchanged
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/io_mmio_ctrl.sv
// Memory-mapped I/O target: UART RX/TX byte buffers, cycle and retired
// instruction counters, and registered load data with dmem-like latency.
// Define IO_TX_FIFO_EN to replace the TX holding register with a
// TX_FIFO_DEPTH-entry FIFO.
module io_mmio_ctrl
    import io_mmio_ctrl_pkg::*;
#(
    parameter int CTR_WIDTH     = 32,
    parameter int TX_FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_io_trans,
    input  logic        i_io_recv,
    input  logic [31:0] i_store_data,
    input  logic        i_stall,
    input  logic        i_inst_valid,
    output logic [31:0] o_io_rdata,
    output logic [7:0]  o_uart_tx_data_in,
    output logic        o_uart_tx_data_in_valid,
    input  logic        i_uart_tx_data_in_ready,
    input  logic [7:0]  i_uart_rx_data_out,
    input  logic        i_uart_rx_data_out_valid,
    output logic        o_uart_rx_data_out_ready
);
    logic [7:0]           w_off;
    logic                 w_store;
    logic                 w_load;
    logic                 w_tx_push;
    logic                 w_ctr_clr;
    logic                 w_rx_pop;
    logic                 w_ovf_clr;
    logic                 w_rx_capture;
    logic [7:0]           w_tx_byte;
    logic                 w_tx_full;
    logic                 w_tx_drain;
    logic                 w_tx_ovf_set;
    logic [31:0]          w_rdata;
    logic                 w_unused;

    logic [31:0]          r_rdata;
    logic                 r_rx_full;
    logic [7:0]           r_rx_byte;
    logic                 r_tx_ovf;
    logic [CTR_WIDTH-1:0] r_cycle;
    logic [CTR_WIDTH-1:0] r_instret;

    // Side effects of I/O accesses are suppressed while the pipeline stalls
    assign w_off        = word_offset(i_addr[7:0]);
    assign w_store      = (|i_io_trans) & ~i_stall;
    assign w_load       = i_io_recv & ~i_stall;
    assign w_tx_push    = w_store && (w_off == IO_UART_TX);
    assign w_ctr_clr    = w_store && (w_off == IO_CTR_RST);
    assign w_rx_pop     = w_load && (w_off == IO_UART_RX);
    assign w_ovf_clr    = w_load && (w_off == IO_UART_CTRL);
    assign w_rx_capture = i_uart_rx_data_out_valid & ~r_rx_full;
    assign w_tx_byte    = lane_byte(i_store_data, i_addr[1:0]);
    assign w_tx_ovf_set = w_tx_push & w_tx_full & ~w_tx_drain;

    assign o_uart_rx_data_out_ready = ~r_rx_full;
    assign o_io_rdata               = r_rdata;
    assign w_unused                 = ^{i_addr[31:8], TX_FIFO_DEPTH[0]};

`ifdef IO_TX_FIFO_EN
    logic w_tx_empty;
    logic [7:0] w_tx_dout;

    assign w_tx_drain              = ~w_tx_empty & i_uart_tx_data_in_ready;
    assign o_uart_tx_data_in_valid = ~w_tx_empty;
    assign o_uart_tx_data_in       = w_tx_dout;

    io_tx_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_tx_push),
        .i_din   (w_tx_byte),
        .i_pop   (w_tx_drain),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_dout  (w_tx_dout)
    );
`else
    logic       r_tx_full;
    logic [7:0] r_tx_data;

    assign w_tx_full               = r_tx_full;
    assign w_tx_drain              = r_tx_full & i_uart_tx_data_in_ready;
    assign o_uart_tx_data_in_valid = r_tx_full;
    assign o_uart_tx_data_in       = r_tx_data;

    // Holding register: a drain frees the slot in time for a same-cycle push
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_full <= 1'b0;
            r_tx_data <= '0;
        end else if (w_tx_push && !w_tx_ovf_set) begin
            r_tx_full <= 1'b1;
            r_tx_data <= w_tx_byte;
        end else if (w_tx_drain) begin
            r_tx_full <= 1'b0;
        end
    end
`endif

    // Sticky overflow flag; a set in the same cycle as a status read wins
    always_ff @(posedge i_clk) begin
        if (i_reset)           r_tx_ovf <= 1'b0;
        else if (w_tx_ovf_set) r_tx_ovf <= 1'b1;
        else if (w_ovf_clr)    r_tx_ovf <= 1'b0;
    end

    // RX holding register; a capture only happens while empty, so it never collides with a pop of a held byte
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rx_full <= 1'b0;
            r_rx_byte <= '0;
        end else if (w_rx_capture) begin
            r_rx_full <= 1'b1;
            r_rx_byte <= i_uart_rx_data_out;
        end else if (w_rx_pop) begin
            r_rx_full <= 1'b0;
        end
    end

    // Ready is low whenever a byte is held, so pop-of-full and capture are exclusive
    always_ff @(posedge i_clk) begin
        if (!i_reset) assert (!(w_rx_pop && w_rx_capture && r_rx_full));
    end

    // Free-running cycle counter and retired-instruction counter; a clear beats an increment
    always_ff @(posedge i_clk) begin
        if (i_reset || w_ctr_clr) begin
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            r_cycle <= r_cycle + CTR_WIDTH'(1);
            if (i_inst_valid && !i_stall) r_instret <= r_instret + CTR_WIDTH'(1);
        end
    end

    // Load data mux over pre-edge state
    always_comb begin
        w_rdata = '0;
        case (w_off)
            IO_UART_CTRL: begin
                w_rdata[CTRL_TX_READY] = ~w_tx_full;
                w_rdata[CTRL_RX_FULL]  = r_rx_full;
                w_rdata[CTRL_TX_OVF]   = r_tx_ovf;
            end
            IO_UART_RX: w_rdata = {24'b0, r_rx_byte};
            IO_CYCLE:   w_rdata = 32'(r_cycle);
            IO_INSTRET: w_rdata = 32'(r_instret);
            default:    w_rdata = '0;
        endcase
    end

    // Load data register: refreshed by every load strobe, stalled or not, held otherwise
    always_ff @(posedge i_clk) begin
        if (i_reset)        r_rdata <= '0;
        else if (i_io_recv) r_rdata <= w_rdata;
    end

endmodule
